// File: rtl/rx_bytes_des.sv
`default_nettype none
// ============================================================================
//  Module   : rx_bytes_des
//  Brief    : Asynchronous serial byte receiver with frame assembly.
//             A bit-level FSM recovers 8N1 bytes from the line at one of two
//             bit rates. A frame-level FSM writes the bytes of a
//             length-prefixed frame into a buffer and checks a
//             CRC-16/MODBUS trailer.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_bytes_des (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div_ls,
  input  logic [15:0] div_hs,
  input  logic [7:0]  idle_wait_len,
  input  logic        user_crc,
  input  logic        abort,
  input  logic        rx,
  input  logic        rx_free,
  output logic        bus_idle,
  output logic        rx_bit_inc,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_addr,
  output logic        wr_en,
  output logic        frame_done,
  output logic        crc_err,
  output logic        error,
  output logic        lost
);

  typedef enum logic [0:0] {
    WAIT = 1'b0,
    BITS = 1'b1
  } bit_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RECV = 2'd1,
    F_DROP = 2'd2
  } frame_state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // One byte of reflected CRC-16, processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic        rx_meta;
  logic        rx_s;
  logic        rx_s_d;

  bit_state_t  bit_state;
  bit_state_t  bit_next;
  logic [15:0] div_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [15:0] div_cur;
  logic [15:0] div_lim;
  logic [15:0] div_half;
  logic        start_edge;
  logic        wrap;
  logic        sample_pt;
  logic        byte_done;
  logic        stop_err;

  logic [7:0]  idle_cnt;
  logic [7:0]  idle_next;
  logic        hs_flag;

  frame_state_t f_state;
  frame_state_t f_next;
  logic [8:0]  byte_cnt;
  logic [8:0]  cnt_next;
  logic [8:0]  cnt_inc;
  logic [7:0]  data_len;
  logic [7:0]  len_next;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [15:0] crc_upd;
  logic        wr_en_n;
  logic [7:0]  wr_data_n;
  logic [7:0]  wr_addr_n;
  logic        done_n;
  logic        crcerr_n;
  logic        err_n;
  logic        lost_n;

  // --------------------------------------------------------------------------
  // Line synchronizer; flops reset to the idle (high) level
  // --------------------------------------------------------------------------
  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // --------------------------------------------------------------------------
  // Bit timing
  // --------------------------------------------------------------------------
  // While waiting for a start bit the timer always runs at the low-speed rate,
  // so rx_bit_inc and the idle count are rate independent between frames.
  assign div_cur    = hs_flag ? div_hs : div_ls;
  assign div_lim    = (bit_state == BITS) ? div_cur : div_ls;
  assign div_half   = {1'b0, div_cur[15:1]};
  assign start_edge = (bit_state == WAIT) && rx_s_d && !rx_s;
  assign wrap       = (div_cnt >= div_lim);
  assign sample_pt  = (bit_state == BITS) && (div_cnt == div_half);

  // Bit FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bit_state <= WAIT;
    else       bit_state <= bit_next;
  end

  // Bit FSM next state plus byte-complete / stop-error strobes.
  always_comb begin
    bit_next  = bit_state;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    if (abort) begin
      bit_next = WAIT;
    end else begin
      case (bit_state)
        WAIT: begin
          if (start_edge) bit_next = BITS;
        end
        BITS: begin
          if (sample_pt) begin
            if (bit_cnt == 4'd0) begin
              // A start bit that is high again at mid-bit was only a glitch.
              if (rx_s) bit_next = WAIT;
            end else if (bit_cnt == 4'd9) begin
              bit_next = WAIT;
              if (rx_s) byte_done = 1'b1;
              else      stop_err  = 1'b1;
            end else if (bit_cnt > 4'd9) begin
              bit_next = WAIT;
            end
          end
        end
        default: bit_next = WAIT;
      endcase
    end
  end

  // Divider, bit counter, bit-period pulse and data shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= 16'd1;
      bit_cnt    <= 4'd0;
      rx_bit_inc <= 1'b0;
      shift_reg  <= 8'h00;
    end else begin
      rx_bit_inc <= 1'b0;
      if (start_edge && !abort) begin
        // The edge clock itself counts as the first clock of the start bit.
        div_cnt <= 16'd1;
        bit_cnt <= 4'd0;
      end else if (wrap) begin
        div_cnt    <= 16'd0;
        rx_bit_inc <= 1'b1;
        if (bit_state == BITS) bit_cnt <= bit_cnt + 4'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
      if (sample_pt && (bit_cnt >= 4'd1) && (bit_cnt <= 4'd8)) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Idle detection and speed selection
  // --------------------------------------------------------------------------
  always_comb begin
    idle_next = idle_cnt;
    if (!rx_s) begin
      idle_next = 8'd0;
    end else if ((bit_state == WAIT) && wrap && (idle_cnt != 8'hFF)) begin
      idle_next = idle_cnt + 8'd1;
    end
  end

  // Saturating idle counter and bus_idle flag; any low level clears both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= 8'd0;
      bus_idle <= 1'b0;
    end else begin
      idle_cnt <= idle_next;
      bus_idle <= rx_s && (idle_next >= idle_wait_len);
    end
  end

  // High-speed flag: the first byte of every frame is always taken at div_ls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_flag <= 1'b0;
    end else if (abort || bus_idle) begin
      hs_flag <= 1'b0;
    end else if (byte_done) begin
      hs_flag <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame assembly
  // --------------------------------------------------------------------------
  assign crc_upd = crc16_byte(crc, shift_reg);
  assign cnt_inc = byte_cnt + 9'd1;

  // Frame FSM, counters and CRC state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_state  <= F_IDLE;
      byte_cnt <= 9'd0;
      data_len <= 8'd0;
      crc      <= CRC_INIT;
    end else begin
      f_state  <= f_next;
      byte_cnt <= cnt_next;
      data_len <= len_next;
      crc      <= crc_next;
    end
  end

  // Frame FSM next state and next values of the write port and status pulses.
  // Within a clock the pulses are mutually exclusive: error > crc_err > done.
  always_comb begin
    f_next    = f_state;
    cnt_next  = byte_cnt;
    len_next  = data_len;
    crc_next  = crc;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    wr_addr_n = wr_addr;
    done_n    = 1'b0;
    crcerr_n  = 1'b0;
    err_n     = 1'b0;
    lost_n    = 1'b0;
    if (abort) begin
      f_next   = F_DROP;
      cnt_next = 9'd0;
      crc_next = CRC_INIT;
    end else begin
      case (f_state)
        F_IDLE: begin
          cnt_next = 9'd0;
          crc_next = CRC_INIT;
          if (stop_err) begin
            err_n  = 1'b1;
            f_next = F_DROP;
          end else if (byte_done) begin
            if (rx_free) begin
              f_next    = F_RECV;
              wr_en_n   = 1'b1;
              wr_data_n = shift_reg;
              wr_addr_n = 8'h00;
              cnt_next  = 9'd1;
              crc_next  = crc16_byte(CRC_INIT, shift_reg);
            end else begin
              lost_n = 1'b1;
              f_next = F_DROP;
            end
          end
        end
        F_RECV: begin
          if (stop_err) begin
            err_n  = 1'b1;
            f_next = F_DROP;
          end else if (bus_idle) begin
            // Line went idle before the announced length arrived.
            err_n  = 1'b1;
            f_next = F_IDLE;
          end else if (byte_done) begin
            wr_en_n   = 1'b1;
            wr_data_n = shift_reg;
            wr_addr_n = byte_cnt[7:0];
            cnt_next  = cnt_inc;
            crc_next  = crc_upd;
            if (byte_cnt == 9'd2) len_next = shift_reg;
            if (cnt_inc > 9'd255) begin
              err_n  = 1'b1;
              f_next = F_DROP;
            end else if (byte_cnt == ({1'b0, data_len} + 9'd4)) begin
              // Residue over data plus both CRC bytes is zero for a good frame.
              if ((crc_upd == 16'h0000) || user_crc) done_n   = 1'b1;
              else                                   crcerr_n = 1'b1;
              f_next = F_DROP;
            end
          end
        end
        F_DROP: begin
          cnt_next = 9'd0;
          crc_next = CRC_INIT;
          if (bus_idle) f_next = F_IDLE;
        end
        default: f_next = F_IDLE;
      endcase
    end
  end

  // Registered write port and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_data    <= 8'h00;
      wr_addr    <= 8'h00;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      error      <= 1'b0;
      lost       <= 1'b0;
    end else begin
      wr_en      <= wr_en_n;
      wr_data    <= wr_data_n;
      wr_addr    <= wr_addr_n;
      frame_done <= done_n;
      crc_err    <= crcerr_n;
      error      <= err_n;
      lost       <= lost_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_bytes_des.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_bytes_des
//  Brief    : Scoreboard bench for rx_bytes_des using directed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_bytes_des;

  localparam int LS = 40;   // clocks per bit at div_ls = 39
  localparam int HS = 10;   // clocks per bit at div_hs = 9

  // Frame 01 02 01 55 with CRC-16/MODBUS 0xB761 sent low byte first (61 B7).
  localparam logic [47:0] GOOD   = 48'hB7_61_55_01_02_01;
  localparam logic [47:0] BADCRC = 48'hB6_61_55_01_02_01;

  localparam logic [3:0] EV_DONE = 4'b1000;
  localparam logic [3:0] EV_CRC  = 4'b0100;
  localparam logic [3:0] EV_ERR  = 4'b0010;
  localparam logic [3:0] EV_LOST = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div_ls = 16'd39;
  logic [15:0] div_hs = 16'd9;
  logic [7:0]  idle_wait_len = 8'd10;
  logic        user_crc;
  logic        abort;
  logic        rx;
  logic        rx_free;
  logic        bus_idle;
  logic        rx_bit_inc;
  logic [7:0]  wr_data;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic        frame_done;
  logic        crc_err;
  logic        error;
  logic        lost;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_wr[$];
  logic [3:0]  exp_ev[$];

  always #5 clk = ~clk;

  rx_bytes_des dut (
    .clk          (clk),
    .reset        (reset),
    .div_ls       (div_ls),
    .div_hs       (div_hs),
    .idle_wait_len(idle_wait_len),
    .user_crc     (user_crc),
    .abort        (abort),
    .rx           (rx),
    .rx_free      (rx_free),
    .bus_idle     (bus_idle),
    .rx_bit_inc   (rx_bit_inc),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .frame_done   (frame_done),
    .crc_err      (crc_err),
    .error        (error),
    .lost         (lost)
  );

  // Monitor: pops the scoreboard whenever the DUT writes or pulses a status.
  always @(negedge clk) begin
    logic [15:0] ew;
    logic [3:0]  ee;
    logic [3:0]  ev;
    if (!reset) begin
      if (wr_en) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected: addr=%h data=%h, none expected", wr_addr, wr_data);
        end else begin
          ew = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== ew) begin
            bad++;
            $display("FAIL wr: addr/data=%h/%h expected %h/%h", wr_addr, wr_data, ew[15:8], ew[7:0]);
          end
        end
      end
      ev = {frame_done, crc_err, error, lost};
      if (ev != 4'b0000) begin
        total++;
        if (exp_ev.size() == 0) begin
          bad++;
          $display("FAIL ev_unexpected: {done,crc,err,lost}=%b, none expected", ev);
        end else begin
          ee = exp_ev.pop_front();
          if (ev !== ee) begin
            bad++;
            $display("FAIL ev: {done,crc,err,lost}=%b expected %b", ev, ee);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input int n, input logic stop, input logic do_abort);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      if (do_abort && i == 3) begin
        rx = d[i];
        repeat (n / 2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (n - n / 2 - 1) tick();
      end else begin
        drive_bit(d[i], n);
      end
    end
    drive_bit(stop, n);
  endtask

  task automatic send_frame(input logic [47:0] f, input int bad_stop, input int abort_at);
    for (int k = 0; k < 6; k++) begin
      int n;
      n = (k == 0) ? LS : HS;
      send_byte(f[8*k +: 8], n, (k != bad_stop), (k == abort_at));
      if (k == bad_stop) drive_bit(1'b1, n);
    end
    rx = 1'b1;
  endtask

  task automatic push_writes(input logic [47:0] f, input int cnt);
    for (int k = 0; k < cnt; k++) exp_wr.push_back({8'(k), f[8*k +: 8]});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus_idle && n < 3000) begin
      tick();
      n++;
    end
    check({name, " bus_idle"}, 32'(bus_idle), 32'd1);
    repeat (3) tick();
  endtask

  task automatic drained(input string name);
    check({name, " wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, " ev_left"}, 32'(exp_ev.size()), 32'd0);
  endtask

  task automatic good_frame(input string name);
    push_writes(GOOD, 6);
    exp_ev.push_back(EV_DONE);
    send_frame(GOOD, -1, -1);
    wait_idle(name);
    drained(name);
  endtask

  initial begin
    int p;
    int n;
    reset    = 1'b1;
    rx       = 1'b1;
    abort    = 1'b0;
    user_crc = 1'b0;
    rx_free  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst bus_idle",   32'(bus_idle),   32'd0);
    check("rst rx_bit_inc", 32'(rx_bit_inc), 32'd0);
    check("rst wr_en",      32'(wr_en),      32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst crc_err",    32'(crc_err),    32'd0);
    check("rst error",      32'(error),      32'd0);
    check("rst lost",       32'(lost),       32'd0);
    check("rst wr_data",    32'(wr_data),    32'd0);
    check("rst wr_addr",    32'(wr_addr),    32'd0);
    reset = 1'b0;

    // Idle detection: bus_idle rises together with the 10th bit pulse
    p = 0;
    n = 0;
    while (p < 9 && n < 1000) begin
      tick();
      n++;
      if (rx_bit_inc) p++;
    end
    check("idle after 9 bits", 32'(bus_idle), 32'd0);
    while (p < 10 && n < 1000) begin
      tick();
      n++;
      if (rx_bit_inc) p++;
    end
    check("idle pulse count", 32'(p), 32'd10);
    check("idle after 10 bits", 32'(bus_idle), 32'd1);

    // Good frame
    good_frame("good");

    // Corrupted CRC byte
    push_writes(BADCRC, 6);
    exp_ev.push_back(EV_CRC);
    send_frame(BADCRC, -1, -1);
    wait_idle("badcrc");
    drained("badcrc");

    // Corrupted CRC byte with CRC checking bypassed
    user_crc = 1'b1;
    push_writes(BADCRC, 6);
    exp_ev.push_back(EV_DONE);
    send_frame(BADCRC, -1, -1);
    wait_idle("usercrc");
    drained("usercrc");
    user_crc = 1'b0;

    // Stop bit low on byte 3, then a normal frame
    push_writes(GOOD, 3);
    exp_ev.push_back(EV_ERR);
    send_frame(GOOD, 3, -1);
    wait_idle("stoperr");
    drained("stoperr");
    good_frame("after stoperr");

    // 0.3-bit low glitch
    drive_bit(1'b0, 12);
    rx = 1'b1;
    check("glitch clears idle", 32'(bus_idle), 32'd0);
    p = 0;
    n = 0;
    while (!bus_idle && n < 1000) begin
      tick();
      n++;
      if (rx_bit_inc) p++;
    end
    check("glitch idle back", 32'(bus_idle), 32'd1);
    check("glitch pulse count", 32'(p), 32'd10);
    repeat (3) tick();
    drained("glitch");

    // No receive buffer at the first byte
    rx_free = 1'b0;
    exp_ev.push_back(EV_LOST);
    send_frame(GOOD, -1, -1);
    wait_idle("lost");
    drained("lost");
    rx_free = 1'b1;

    // Abort in the middle of byte 2
    push_writes(GOOD, 2);
    send_frame(GOOD, -1, 2);
    wait_idle("abort");
    drained("abort");
    good_frame("after abort");

    // Reset in the middle of byte 1
    push_writes(GOOD, 1);
    send_byte(8'h01, LS, 1'b1, 1'b0);
    drive_bit(1'b0, HS);
    drive_bit(1'b1, HS / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    wait_idle("midreset");
    drained("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
